// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin scheduler sharing one half-precision fpmul among NREQ requesters,
// with operand issue, result watchdog and response routing. Rev 1.0
`default_nettype none

module fpmul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_y,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [15:0]          mul_x1,
  output logic [15:0]          mul_x2,
  output logic                 mul_en,
  input  logic                 mul_ready,
  input  logic [15:0]          mul_y
);

  localparam int              IW       = $clog2(NREQ);
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [15:0]     QNAN     = 16'h7E00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   g_q, g_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     x1_q, x1_d;
  logic [15:0]     x2_q, x2_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_y_q, rsp_y_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;
  logic            mul_en_q, mul_en_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW:0]     idx;

  // Scan downward so the candidate closest above ptr is the last one written.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (IW + 1)'(k);
      if (idx >= (IW + 1)'(NREQ)) idx = idx - (IW + 1)'(NREQ);
      if (req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    ack_d       = '0;
    rsp_valid_d = '0;
    rsp_y_d     = rsp_y_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    mul_en_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          g_d      = pick;
          x1_d     = req_a[16*int'(pick) +: 16];
          x2_d     = req_b[16*int'(pick) +: 16];
          ack_d    = NREQ'(1) << pick;
          mul_en_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last watchdog cycle still counts as a result.
        if (mul_ready) begin
          rsp_y_d     = mul_y;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << g_q;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_y_d     = QNAN;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NREQ'(1) << g_q;
          state_d     = S_RESP;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        ptr_d   = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      cnt_q       <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mul_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      mul_en_q    <= mul_en_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign mul_x1    = x1_q;
  assign mul_x2    = x2_q;
  assign mul_en    = mul_en_q;

endmodule

`default_nettype wire

// File: tb/tb_fpmul_arbiter.sv
// tb_fpmul_arbiter: directed and randomized transactions against a round-robin reference model.
`default_nettype none

module tb_fpmul_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [16*NREQ-1:0] req_a = '0;
  logic [16*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_y;
  logic              rsp_err;
  logic              busy;
  logic [15:0]       mul_x1;
  logic [15:0]       mul_x2;
  logic              mul_en;
  logic              mul_ready = 1'b0;
  logic [15:0]       mul_y = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int ptr_m  = 0;

  fpmul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
    .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_en(mul_en),
    .mul_ready(mul_ready), .mul_y(mul_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_model(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return -1;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_y"}, 32'(rsp_y), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_mul_x1"}, 32'(mul_x1), 0);
    chk({tag, "_mul_x2"}, 32'(mul_x2), 0);
    chk({tag, "_mul_en"}, 32'(mul_en), 0);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'($urandom);
      req_b[16*i +: 16] = 16'($urandom);
    end
  endtask

  // Called in an IDLE cycle with req already driven. lat = cycles from mul_en to
  // mul_ready (0 = never). Returns in the following IDLE cycle.
  task automatic txn(input int lat, input logic [15:0] yval, input bit stray_issue);
    int g, resp_c;
    bit ok;
    logic [15:0] ey, ea, eb;
    g = pick_model(req);
    chk("model_has_request", 32'(g >= 0), 1);
    if (g < 0) g = 0;
    ok     = (lat >= 1) && (lat <= TIMEOUT);
    resp_c = ok ? lat + 2 : TIMEOUT + 2;
    ey     = ok ? yval : 16'h7E00;
    ea     = req_a[16*g +: 16];
    eb     = req_b[16*g +: 16];
    @(posedge clk); #1;
    chk("issue_ack", 32'(ack), 32'(1) << g);
    chk("issue_mul_en", 32'(mul_en), 1);
    chk("issue_x1", 32'(mul_x1), 32'(ea));
    chk("issue_x2", 32'(mul_x2), 32'(eb));
    chk("issue_busy", 32'(busy), 1);
    if (stray_issue) begin
      mul_ready = 1'b1;
      mul_y     = 16'($urandom);
    end
    for (int c = 2; c <= resp_c; c++) begin
      @(posedge clk); #1;
      mul_ready = 1'b0;
      chk("wait_busy", 32'(busy), 1);
      chk("wait_x1_held", 32'(mul_x1), 32'(ea));
      chk("wait_x2_held", 32'(mul_x2), 32'(eb));
      chk("wait_ack_low", 32'(ack), 0);
      chk("wait_mul_en_low", 32'(mul_en), 0);
      if (c < resp_c) begin
        chk("early_rsp_valid", 32'(rsp_valid), 0);
      end else begin
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << g);
        chk("rsp_y", 32'(rsp_y), 32'(ey));
        chk("rsp_err", 32'(rsp_err), 32'(!ok));
      end
      if (c == lat + 1) begin
        mul_ready = 1'b1;
        mul_y     = yval;
      end
    end
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    chk("idle_rsp_y_held", 32'(rsp_y), 32'(ey));
    ptr_m = (g + 1) % NREQ;
  endtask

  initial begin
    rand_ops();
    // Asynchronous reset from time zero.
    #3;
    all_zero("reset");
    @(posedge clk); @(posedge clk); #4;
    rst = 1'b1;
    @(posedge clk); #1;

    // Stray mul_ready while idle.
    for (int i = 0; i < 3; i++) begin
      mul_ready = 1'b1;
      mul_y     = 16'($urandom);
      @(posedge clk); #1;
      chk("stray_idle_busy", 32'(busy), 0);
      chk("stray_idle_rsp_valid", 32'(rsp_valid), 0);
      chk("stray_idle_mul_en", 32'(mul_en), 0);
    end
    mul_ready = 1'b0;

    // Round robin with all requesters held high.
    req = 4'b1111;
    for (int i = 0; i < 8; i++) txn($urandom_range(1, 6), 16'($urandom), 1'b0);

    // Wrap and skip.
    req = 4'b1010;
    txn(2, 16'($urandom), 1'b0);
    txn(3, 16'($urandom), 1'b0);

    // Single request 1.0 * 2.0.
    req = '0;
    req_a[15:0] = 16'h3C00;
    req_b[15:0] = 16'h4000;
    @(posedge clk); #1;
    req = 4'b0001;
    txn(4, 16'h4000, 1'b0);

    // Watchdog with no result.
    req = 4'b0100;
    txn(0, 16'h0000, 1'b0);

    // Result on the exact timeout cycle.
    req = 4'b0010;
    txn(TIMEOUT, 16'h5A5A, 1'b0);

    // Stray mul_ready during ISSUE.
    req = 4'b1000;
    txn(3, 16'h1234, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 12; i++) begin
      logic [NREQ-1:0] m;
      req = '0;
      rand_ops();
      @(posedge clk); #1;
      m = NREQ'($urandom_range(1, 15));
      req = m;
      txn($urandom_range(0, TIMEOUT + 2), 16'($urandom), 1'($urandom));
    end

    // Reset in the middle of WAIT.
    req = '0;
    rand_ops();
    @(posedge clk); #1;
    req = 4'b0100;
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    #1;
    all_zero("mid_reset");
    #1;
    rst = 1'b1;
    ptr_m = 0;
    @(posedge clk); #1;
    mul_ready = 1'b1;
    mul_y     = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mul_ready = 1'b0;
      chk("post_reset_rsp_valid", 32'(rsp_valid), 0);
      chk("post_reset_busy", 32'(busy), 0);
    end

    // Pointer restarts from requester 0.
    req = 4'b1111;
    txn(2, 16'($urandom), 1'b0);
    req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
